dm_abs_cmd_mh: RTL



---
 rtl/dm_abs_cmd_mh.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/dm_abs_cmd_mh.sv
// Multi-hart abstract-command engine for the debug module.
// Decodes access-register commands, issues them to the hart chosen by
// hartsel, waits (bounded) for that hart's acknowledgement and reports the
// outcome through busy / cmderr / cmd_finished.
module dm_abs_cmd_mh #(
  parameter int unsigned NUM_HARTS      = 4,
  parameter int unsigned HARTSEL_WIDTH  = 2,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                            sys_clk,
  input  logic                            sys_rst,
  input  logic                            cmd_update,
  input  logic [31:0]                     command,
  input  logic                            exec_repeat,
  input  logic [HARTSEL_WIDTH-1:0]        hartsel,
  input  logic [DATA_WIDTH-1:0]           data0,
  input  logic [NUM_HARTS-1:0]            halted,
  input  logic [2:0]                      cmderr_clr,
  output logic                            busy,
  output logic [2:0]                      cmderr,
  output logic                            cmd_finished,
  output logic                            cmd_read_data_valid,
  output logic [DATA_WIDTH-1:0]           cmd_read_data,
  output logic                            command_wr,
  output logic [31:0]                     command_next,
  output logic [NUM_HARTS-1:0]            dbg_reg_access,
  output logic                            dbg_wr1_rd0,
  output logic [15:0]                     dbg_regno,
  output logic [DATA_WIDTH-1:0]           dbg_write_data,
  input  logic [NUM_HARTS-1:0]            dbg_read_data_valid,
  input  logic [NUM_HARTS*DATA_WIDTH-1:0] dbg_read_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_BUSY    = 3'd1;
  localparam logic [2:0] ERR_NOTSUP  = 3'd2;
  localparam logic [2:0] ERR_EXCEPT  = 3'd3;
  localparam logic [2:0] ERR_HALTRES = 3'd4;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                   state;
  logic [31:0]              cmd_q;
  logic [HARTSEL_WIDTH-1:0] hart_q;
  logic [7:0]               wait_cnt;

  logic                     trig;
  logic [31:0]              cmd_sel;
  logic [31:0]              cmd_inc;
  logic                     hart_valid;
  logic                     halted_sel;
  logic [NUM_HARTS-1:0]     req_onehot;
  logic [2:0]               dec_err;
  logic                     ack_sel;
  logic [DATA_WIDTH-1:0]    rdata_sel;

  // Trigger selection, command decode and per-hart muxing
  always_comb begin
    trig       = cmd_update | exec_repeat;
    cmd_sel    = cmd_update ? command : cmd_q;
    cmd_inc    = {cmd_q[31:16], cmd_q[15:0] + 16'd1};
    hart_valid = 1'b0;
    halted_sel = 1'b0;
    req_onehot = '0;
    ack_sel    = 1'b0;
    rdata_sel  = '0;
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      if (hartsel == HARTSEL_WIDTH'(h)) begin
        hart_valid    = 1'b1;
        halted_sel    = halted[h];
        req_onehot[h] = 1'b1;
      end
      if (hart_q == HARTSEL_WIDTH'(h)) begin
        ack_sel   = dbg_read_data_valid[h];
        rdata_sel = dbg_read_data[h*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    dec_err = ERR_NONE;
    if (cmd_sel[31:24] != 8'd0)
      dec_err = ERR_NOTSUP;
    else if (cmd_sel[18])
      dec_err = ERR_NOTSUP;
    else if (cmd_sel[17] && (cmd_sel[22:20] != 3'd2))
      dec_err = ERR_NOTSUP;
    else if (!hart_valid)
      dec_err = ERR_HALTRES;
    else if (!halted_sel)
      dec_err = ERR_HALTRES;
  end

  // Command FSM with registered outputs and sticky cmderr
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state               <= S_IDLE;
      cmd_q               <= '0;
      hart_q              <= '0;
      wait_cnt            <= '0;
      busy                <= 1'b0;
      cmderr              <= '0;
      cmd_finished        <= 1'b0;
      cmd_read_data_valid <= 1'b0;
      cmd_read_data       <= '0;
      command_wr          <= 1'b0;
      command_next        <= '0;
      dbg_reg_access      <= '0;
      dbg_wr1_rd0         <= 1'b0;
      dbg_regno           <= '0;
      dbg_write_data      <= '0;
    end else begin
      cmd_finished        <= 1'b0;
      cmd_read_data_valid <= 1'b0;
      command_wr          <= 1'b0;
      dbg_reg_access      <= '0;
      // Later assignments in this block override the W1C clear, so any
      // error raised this cycle takes precedence over a simultaneous clear.
      cmderr              <= cmderr & ~cmderr_clr;
      if (state != S_IDLE && trig && cmderr == ERR_NONE)
        cmderr <= ERR_BUSY;

      case (state)
        S_IDLE: begin
          if (trig && cmderr == ERR_NONE) begin
            if (dec_err != ERR_NONE) begin
              cmderr       <= dec_err;
              cmd_finished <= 1'b1;
            end else if (!cmd_sel[17]) begin
              cmd_finished <= 1'b1;
            end else begin
              cmd_q          <= cmd_sel;
              hart_q         <= hartsel;
              busy           <= 1'b1;
              dbg_reg_access <= req_onehot;
              dbg_wr1_rd0    <= cmd_sel[16];
              dbg_regno      <= cmd_sel[15:0];
              dbg_write_data <= data0;
              wait_cnt       <= '0;
              state          <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (ack_sel) begin
            cmd_finished <= 1'b1;
            if (!dbg_wr1_rd0) begin
              cmd_read_data       <= rdata_sel;
              cmd_read_data_valid <= 1'b1;
            end
            // The incremented command is kept locally as well so that an
            // autoexec re-issue continues from the next register.
            if (cmd_q[19]) begin
              command_wr   <= 1'b1;
              command_next <= cmd_inc;
              cmd_q        <= cmd_inc;
            end
            state <= S_DONE;
          end else if (wait_cnt == TMO_LAST) begin
            cmderr       <= ERR_EXCEPT;
            cmd_finished <= 1'b1;
            state        <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
